// File: rtl/peripheral_dbg_arb_pkg.sv
// Shared types and Wishbone B3 cycle-type encodings for the debug-RAM arbiter.
package peripheral_dbg_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TOUT  = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/peripheral_dbg_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master not served last.
module peripheral_dbg_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  assign gnt_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/peripheral_dbg_ram_arb_axi4.sv
// Round-robin arbiter sharing the debug-bench RAM slave between two Wishbone B3 masters,
// holding the grant for a whole bus cycle and aborting transfers the slave never answers.
module peripheral_dbg_ram_arb_axi4
  import peripheral_dbg_arb_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 axi4_clk_i,
  input  logic                 axi4_rst_ni,
  input  logic [1:0][AW-1:0]   m_adr_i,
  input  logic [1:0][DW-1:0]   m_dat_i,
  input  logic [1:0][3:0]      m_sel_i,
  input  logic [1:0]           m_we_i,
  input  logic [1:0][1:0]      m_bte_i,
  input  logic [1:0][2:0]      m_cti_i,
  input  logic [1:0]           m_cyc_i,
  input  logic [1:0]           m_stb_i,
  output logic [1:0]           m_ack_o,
  output logic [1:0]           m_err_o,
  output logic [1:0]           m_rty_o,
  output logic [1:0][DW-1:0]   m_dat_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic [1:0]           s_bte_o,
  output logic [2:0]           s_cti_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,
  input  logic [DW-1:0]        s_dat_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  arb_state_t    r_state;
  logic          r_grant;
  logic          r_last;
  logic [CW-1:0] r_wait_cnt;

  logic [1:0]    w_req;
  logic          w_gnt_valid;
  logic          w_gnt_idx;
  logic          w_resp;
  logic          w_stall;
  logic          w_timeout;
  logic          w_granted;

  assign w_req = m_cyc_i & m_stb_i;

  peripheral_dbg_arb_rr2 u_rr2 (
    .req       (w_req),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // A beat is stalled while the owner strobes and the slave has not answered at all.
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_stall   = m_stb_i[r_grant] & ~w_resp;
  assign w_timeout = w_stall && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_granted = (r_state == ARB_GRANT);

  always_ff @(posedge axi4_clk_i or negedge axi4_rst_ni) begin
    if (!axi4_rst_ni) begin
      r_state    <= ARB_IDLE;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_wait_cnt <= '0;
          if (w_gnt_valid) begin
            r_state <= ARB_GRANT;
            r_grant <= w_gnt_idx;
            r_last  <= w_gnt_idx;
          end
        end
        ARB_GRANT: begin
          if (!m_cyc_i[r_grant]) begin
            r_state    <= ARB_IDLE;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_state    <= ARB_TOUT;
            r_wait_cnt <= '0;
          end else if (w_stall) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end else begin
            r_wait_cnt <= '0;
          end
        end
        ARB_TOUT: begin
          r_state    <= ARB_IDLE;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= ARB_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // The slave only ever sees the owner, and only while GRANT; TOUT drops cyc to abort the burst.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_bte_o = '0;
    s_cti_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (w_granted) begin
      s_adr_o          = m_adr_i[r_grant];
      s_dat_o          = m_dat_i[r_grant];
      s_sel_o          = m_sel_i[r_grant];
      s_we_o           = m_we_i[r_grant];
      s_bte_o          = m_bte_i[r_grant];
      s_cti_o          = m_cti_i[r_grant];
      s_cyc_o          = m_cyc_i[r_grant];
      s_stb_o          = m_stb_i[r_grant];
      m_ack_o[r_grant] = s_ack_i;
      m_err_o[r_grant] = s_err_i;
      m_rty_o[r_grant] = s_rty_i;
    end
    if (r_state == ARB_TOUT) begin
      m_err_o[r_grant] = 1'b1;
    end
  end

  assign m_dat_o[0] = s_dat_i;
  assign m_dat_o[1] = s_dat_i;

endmodule

// File: tb/tb_peripheral_dbg_ram_arb_axi4.sv
// Directed and randomized checks of the two-master debug-RAM arbiter against a small RAM slave
// and a transaction-level ownership model.
module tb_peripheral_dbg_ram_arb_axi4;
  import peripheral_dbg_arb_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TOUT = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0][AW-1:0]  mAdr;
  logic [1:0][DW-1:0]  mDatW;
  logic [1:0][DW-1:0]  mDatR;
  logic [1:0][3:0]     mSel;
  logic [1:0]          mWe;
  logic [1:0][1:0]     mBte;
  logic [1:0][2:0]     mCti;
  logic [1:0]          mCyc;
  logic [1:0]          mStb;
  logic [1:0]          mAck;
  logic [1:0]          mErr;
  logic [1:0]          mRty;
  logic [AW-1:0]       sAdr;
  logic [DW-1:0]       sDatW;
  logic [DW-1:0]       sDatR;
  logic [3:0]          sSel;
  logic                sWe;
  logic [1:0]          sBte;
  logic [2:0]          sCti;
  logic                sCyc;
  logic                sStb;
  logic                sAck;
  logic                sErr;
  logic                sRty;
  logic                ackEn;
  logic                rtyEn;
  logic [DW-1:0]       mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peripheral_dbg_ram_arb_axi4 #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(TOUT)) dut (
    .axi4_clk_i (clk),   .axi4_rst_ni (rst_n),
    .m_adr_i    (mAdr),  .m_dat_i     (mDatW), .m_sel_i (mSel), .m_we_i  (mWe),
    .m_bte_i    (mBte),  .m_cti_i     (mCti),  .m_cyc_i (mCyc), .m_stb_i (mStb),
    .m_ack_o    (mAck),  .m_err_o     (mErr),  .m_rty_o (mRty), .m_dat_o (mDatR),
    .s_adr_o    (sAdr),  .s_dat_o     (sDatW), .s_sel_o (sSel), .s_we_o  (sWe),
    .s_bte_o    (sBte),  .s_cti_o     (sCti),  .s_cyc_o (sCyc), .s_stb_o (sStb),
    .s_ack_i    (sAck),  .s_err_i     (sErr),  .s_rty_i (sRty), .s_dat_i (sDatR)
  );

  function automatic logic [DW-1:0] memInit(input int idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Zero-wait RAM slave: answers in the same cycle whenever enabled.
  assign sAck  = sCyc & sStb & ackEn;
  assign sRty  = sCyc & sStb & rtyEn;
  assign sErr  = 1'b0;
  assign sDatR = mem[sAdr[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= memInit(i);
    end else if (sCyc && sStb && sWe && sAck) begin
      mem[sAdr[9:2]] <= sDatW;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                               input logic [2:0] cti, input logic [1:0] bte);
    mCyc[m] = cyc; mStb[m] = stb; mWe[m] = we; mAdr[m] = adr;
    mDatW[m] = dat; mCti[m] = cti; mBte[m] = bte; mSel[m] = 4'hF;
  endtask

  task automatic idleMaster(input int m);
    applyStimulus(m, 1'b0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC, 2'b00);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic doReset();
    idleMaster(0);
    idleMaster(1);
    ackEn = 1'b1;
    rtyEn = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_s_cyc", 64'(sCyc), 64'(0));
    checkOutput("rst_s_stb", 64'(sStb), 64'(0));
    checkOutput("rst_s_adr", 64'(sAdr), 64'(0));
    checkOutput("rst_m_ack", 64'(mAck), 64'(0));
    checkOutput("rst_m_err", 64'(mErr), 64'(0));
    checkOutput("rst_m_dat1", 64'(mDatR[1]), 64'(memInit(0)));
    @(negedge clk);
    rst_n = 1'b1;
    advance();
  endtask

  int             owner;
  int             lastM;
  int             stall;
  int             ackPct;
  bit             toutNow;
  bit             active;
  logic           expCyc;
  logic           expStb;
  logic           expWe;
  logic [AW-1:0]  expAdr;
  logic [1:0]     expAck;
  logic [1:0]     expRty;
  logic [1:0]     expErr;
  logic [AW-1:0]  wrapAdr;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    // Classic write then read-back by master 0.
    applyStimulus(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, CTI_CLASSIC, 2'b00);
    sample();
    checkOutput("t1_cyc_latency", 64'(sCyc), 64'(0));
    advance();
    sample();
    checkOutput("t1_wr_cyc", 64'(sCyc), 64'(1));
    checkOutput("t1_wr_adr", 64'(sAdr), 64'(32'h100));
    checkOutput("t1_wr_dat", 64'(sDatW), 64'(32'hDEADBEEF));
    checkOutput("t1_wr_ack", 64'(mAck), 64'(2'b01));
    advance();
    applyStimulus(0, 1, 1, 0, 32'h100, '0, CTI_CLASSIC, 2'b00);
    sample();
    checkOutput("t1_rd_we", 64'(sWe), 64'(0));
    checkOutput("t1_rd_ack", 64'(mAck), 64'(2'b01));
    checkOutput("t1_rd_dat", 64'(mDatR[0]), 64'(32'hDEADBEEF));
    advance();
    idleMaster(0);
    sample();
    checkOutput("t1_release", 64'({sCyc, mAck}), 64'(0));
    advance();

    // Simultaneous requests after reset: master 0 first, one idle gap, then master 1.
    doReset();
    applyStimulus(0, 1, 1, 0, 32'h10, '0, CTI_CLASSIC, 2'b00);
    applyStimulus(1, 1, 1, 0, 32'h20, '0, CTI_CLASSIC, 2'b00);
    sample();
    checkOutput("t2_no_grant_yet", 64'(sCyc), 64'(0));
    advance();
    sample();
    checkOutput("t2_m0_adr", 64'(sAdr), 64'(32'h10));
    checkOutput("t2_m0_ack", 64'(mAck), 64'(2'b01));
    advance();
    idleMaster(0);
    sample();
    checkOutput("t2_drop_cyc", 64'({sCyc, mAck}), 64'(0));
    advance();
    sample();
    checkOutput("t2_idle_gap", 64'(sCyc), 64'(0));
    advance();
    sample();
    checkOutput("t2_m1_adr", 64'(sAdr), 64'(32'h20));
    checkOutput("t2_m1_ack", 64'(mAck), 64'(2'b10));
    advance();
    idleMaster(1);
    advance();
    applyStimulus(0, 1, 1, 0, 32'h30, '0, CTI_CLASSIC, 2'b00);
    advance();
    sample();
    checkOutput("t2_m0_solo_ack", 64'(mAck), 64'(2'b01));
    advance();
    idleMaster(0);
    advance();
    applyStimulus(0, 1, 1, 0, 32'h40, '0, CTI_CLASSIC, 2'b00);
    applyStimulus(1, 1, 1, 0, 32'h50, '0, CTI_CLASSIC, 2'b00);
    advance();
    sample();
    checkOutput("t2_tie2_adr", 64'(sAdr), 64'(32'h50));
    checkOutput("t2_tie2_ack", 64'(mAck), 64'(2'b10));
    advance();
    idleMaster(1);
    advance();
    advance();
    sample();
    checkOutput("t2_m0_after_adr", 64'(sAdr), 64'(32'h40));
    checkOutput("t2_m0_after_ack", 64'(mAck), 64'(2'b01));
    advance();
    idleMaster(0);
    advance();

    // Master 1 wrap-4 burst at 0x208 while master 0 requests mid-burst.
    applyStimulus(1, 1, 1, 0, 32'h208, '0, CTI_INCR, 2'b01);
    advance();
    for (int b = 0; b < 4; b++) begin
      wrapAdr = (32'h208 & ~32'hF) | ((32'h208 + 32'(4 * b)) & 32'hF);
      if (b == 1) applyStimulus(0, 1, 1, 0, 32'h60, '0, CTI_CLASSIC, 2'b00);
      applyStimulus(1, 1, 1, 0, wrapAdr, '0, (b == 3) ? CTI_EOB : CTI_INCR, 2'b01);
      sample();
      checkOutput($sformatf("t3_adr%0d", b), 64'(sAdr), 64'(wrapAdr));
      checkOutput($sformatf("t3_ack%0d", b), 64'(mAck), 64'(2'b10));
      checkOutput($sformatf("t3_dat%0d", b), 64'(mDatR[1]), 64'(memInit(int'(wrapAdr[9:2]))));
      checkOutput($sformatf("t3_bte%0d", b), 64'(sBte), 64'(2'b01));
      advance();
    end
    idleMaster(1);
    sample();
    checkOutput("t3_m1_drop", 64'({sCyc, mAck}), 64'(0));
    advance();
    sample();
    checkOutput("t3_idle_gap", 64'(sCyc), 64'(0));
    advance();
    sample();
    checkOutput("t3_m0_adr", 64'(sAdr), 64'(32'h60));
    checkOutput("t3_m0_ack", 64'(mAck), 64'(2'b01));
    advance();
    idleMaster(0);
    advance();

    // Stuck slave: error pulse exactly TOUT cycles after forwarding.
    ackEn = 1'b0;
    applyStimulus(0, 1, 1, 0, 32'h70, '0, CTI_CLASSIC, 2'b00);
    advance();
    for (int k = 0; k < TOUT; k++) begin
      sample();
      checkOutput($sformatf("t4_wait%0d", k), 64'({sCyc, mErr}), 64'({1'b1, 2'b00}));
      advance();
    end
    sample();
    checkOutput("t4_err_pulse", 64'(mErr), 64'(2'b01));
    checkOutput("t4_abort", 64'({sCyc, sStb}), 64'(0));
    advance();
    idleMaster(0);
    sample();
    checkOutput("t4_err_once", 64'(mErr), 64'(0));
    ackEn = 1'b1;
    advance();
    applyStimulus(0, 1, 1, 0, 32'h74, '0, CTI_CLASSIC, 2'b00);
    advance();
    sample();
    checkOutput("t4_recover_ack", 64'(mAck), 64'(2'b01));
    advance();
    idleMaster(0);
    advance();

    // Ack arriving on the last allowed wait cycle beats the timeout.
    ackEn = 1'b0;
    applyStimulus(0, 1, 1, 0, 32'h78, '0, CTI_CLASSIC, 2'b00);
    advance();
    for (int k = 0; k < TOUT - 1; k++) advance();
    ackEn = 1'b1;
    sample();
    checkOutput("t4b_late_ack", 64'({mAck, mErr}), 64'({2'b01, 2'b00}));
    advance();
    idleMaster(0);
    sample();
    checkOutput("t4b_no_err", 64'(mErr), 64'(0));
    advance();
    advance();

    // Reset during the third beat of an incrementing burst.
    applyStimulus(0, 1, 1, 0, 32'h300, '0, CTI_INCR, 2'b00);
    advance();
    advance();
    applyStimulus(0, 1, 1, 0, 32'h304, '0, CTI_INCR, 2'b00);
    advance();
    applyStimulus(0, 1, 1, 0, 32'h308, '0, CTI_INCR, 2'b00);
    #1;
    checkOutput("t5_beat2_ack", 64'(mAck), 64'(2'b01));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_cyc", 64'({sCyc, sStb}), 64'(0));
    checkOutput("t5_rst_ack", 64'(mAck), 64'(0));
    applyStimulus(0, 1, 1, 0, 32'h300, '0, CTI_CLASSIC, 2'b00);
    applyStimulus(1, 1, 1, 0, 32'h310, '0, CTI_CLASSIC, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    sample();
    checkOutput("t5_tie_adr", 64'(sAdr), 64'(32'h300));
    checkOutput("t5_tie_ack", 64'(mAck), 64'(2'b01));
    advance();
    idleMaster(0);
    advance();
    advance();
    sample();
    checkOutput("t5_m1_ack", 64'(mAck), 64'(2'b10));
    advance();
    idleMaster(1);
    advance();

    // Random traffic against an ownership-level model of the arbitration rules.
    doReset();
    owner = -1; lastM = 1; stall = 0; toutNow = 0; ackPct = 70;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) ackPct = ($urandom_range(0, 2) == 0) ? 5 : 70;
      for (int m = 0; m < 2; m++) begin
        if (!mCyc[m]) begin
          if ($urandom_range(0, 2) == 0) mCyc[m] = 1'b1;
        end else if ($urandom_range(0, 5) == 0) begin
          mCyc[m] = 1'b0;
        end
        mStb[m]  = mCyc[m] & ($urandom_range(0, 3) != 0);
        mAdr[m]  = 32'($urandom_range(0, 255)) << 2;
        mWe[m]   = 1'($urandom_range(0, 1));
        mDatW[m] = $urandom;
      end
      ackEn = ($urandom_range(0, 99) < ackPct);
      rtyEn = !ackEn && ($urandom_range(0, 7) == 0);

      active = (owner >= 0) && !toutNow;
      expCyc = active ? mCyc[owner] : 1'b0;
      expStb = active ? mStb[owner] : 1'b0;
      expWe  = active ? mWe[owner]  : 1'b0;
      expAdr = active ? mAdr[owner] : '0;
      expAck = '0; expRty = '0; expErr = '0;
      if (active) begin
        expAck[owner] = mCyc[owner] & mStb[owner] & ackEn;
        expRty[owner] = mCyc[owner] & mStb[owner] & rtyEn;
      end
      if (toutNow) expErr[owner] = 1'b1;

      sample();
      checkOutput($sformatf("rnd_cyc@%0d", n), 64'(sCyc), 64'(expCyc));
      checkOutput($sformatf("rnd_stb@%0d", n), 64'(sStb), 64'(expStb));
      checkOutput($sformatf("rnd_we@%0d", n),  64'(sWe),  64'(expWe));
      checkOutput($sformatf("rnd_adr@%0d", n), 64'(sAdr), 64'(expAdr));
      checkOutput($sformatf("rnd_ack@%0d", n), 64'(mAck), 64'(expAck));
      checkOutput($sformatf("rnd_rty@%0d", n), 64'(mRty), 64'(expRty));
      checkOutput($sformatf("rnd_err@%0d", n), 64'(mErr), 64'(expErr));

      if (toutNow) begin
        toutNow = 0;
        owner   = -1;
      end else if (owner < 0) begin
        if (mCyc[0] && mStb[0] && mCyc[1] && mStb[1]) owner = 1 - lastM;
        else if (mCyc[0] && mStb[0])                   owner = 0;
        else if (mCyc[1] && mStb[1])                   owner = 1;
        if (owner >= 0) lastM = owner;
        stall = 0;
      end else if (!mCyc[owner]) begin
        owner = -1;
        stall = 0;
      end else if (mStb[owner] && !(ackEn || rtyEn)) begin
        stall++;
        if (stall == TOUT) begin
          toutNow = 1;
          stall   = 0;
        end
      end else begin
        stall = 0;
      end
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
